sprite_ahb_slave: RTL and testbench
===================================

# sprite_ahb_slave

AHB-Lite slave that holds sprite/tile pixel words and answers the read bursts issued by the Printer's AHB master port. The Printer sends the address, and this block returns pixel words on HRDATA with a configurable number of wait states. CPU or loader writes through the same port fill the memory. It sits on the pixel bus between the Printer and the bus decoder.

## Interface
Parameters:
- ADDR_W, 10, word-address bits; memory depth = 2**ADDR_W words of 32 bits
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per data phase (0..7)

Ports (reset `rst_n` is synchronous, active-low; clock is `clk`):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address; bits [ADDR_W+1:2] index memory
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 half, 010 word
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready (previous transfer done)
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  0 OKAY, 1 ERROR

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY.
  - On acceptance, register the address, write flag, and size.
  - Enter WAIT if WAIT_STATES>0, else DATA.
- IDLE or BUSY transfers, or HSEL=0, are not accepted. They give a zero-wait OKAY response and no memory access.
- FSM states and transitions:
  - IDLE: stays until a transfer is accepted.
  - WAIT: a counter loads WAIT_STATES-1 and decrements; at 0 go to DATA. HREADYOUT=0 throughout.
  - DATA: HREADYOUT=1.
    - Read: HRDATA = mem[registered word addr].
    - Write: HWDATA is committed to memory at the end of this cycle, with byte enables.
    - A new transfer accepted in DATA goes back to WAIT or DATA; otherwise go to IDLE.
  - ERR1/ERR2: compiled only with the error feature (see Configuration).
- Byte enables on write:
  - Byte: lane HADDR[1:0].
  - Half: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all four lanes.
  - Misaligned half/word: low address bits are ignored (force alignment).
- Reads always return the full 32-bit word, whatever HSIZE is.
- HRDATA holds its last read value outside read DATA cycles. It is 0 only after reset.
- Reads are not stalled by writes. A read of the word written by the immediately preceding transfer returns the new data, because the write commits before the read's DATA cycle.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
  - Memory contents are not reset.
- Reset during WAIT/DATA/ERR: the transfer is abandoned and no write is committed. The outputs take their reset values in the next cycle.

## Timing
- WAIT_STATES=N: a read returns data N+1 cycles after the address-phase edge. HREADYOUT is low for exactly N cycles.
- Back-to-back NONSEQ/SEQ with N=0: one word per cycle, HREADYOUT held 1.
- The next address phase overlaps the current DATA cycle, per AHB-Lite pipelining. No address is accepted while HREADYOUT=0, because HREADY=0.

## Configuration
- SPRITE_SLV_ERR_EN defined:
  - Conditions: HADDR beyond 2**ADDR_W words, or HSIZE>010.
  - Response: two-cycle ERROR, ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). No wait states are inserted and memory is not accessed.
- Not defined:
  - Word index wraps modulo depth.
  - HSIZE>010 is treated as word.
  - HRESP is tied 0 and the ERR states are absent.

## Structure
- sprite_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HSIZE_BYTE/HALF/WORD constants.
  - HRESP_OKAY/ERROR constants.
  - FSM state encodings.
- One sub-module, sprite_ram: 2**ADDR_W x 32 single-port array with 4-bit byte-enable write and asynchronous read.
- The FSM, wait counter, and lane decode live in the top.

## Test plan
- Reset, then 8 NONSEQ/SEQ word reads at 0x00..0x1C:
  - Preload memory with 32'h0601_0601..32'h7671_7671.
  - WAIT_STATES=1: each word appears after 1 HREADYOUT-low cycle, in order.
- WAIT_STATES=0 burst of 4 reads: HREADYOUT never drops and the data streams one word per cycle.
- Byte write 8'hAA to 0x05, then word read of 0x04 over old 32'h1611_1611: returns 32'h1611_AA11.
- Write 32'hDEAD_BEEF to 0x10, then immediate read of 0x10: returns 32'hDEAD_BEEF.
- rst_n low during a WAIT cycle of a write to 0x08:
  - Next cycle: HREADYOUT=1, HRDATA=0.
  - A later read of 0x08 returns the old value.
- With SPRITE_SLV_ERR_EN and ADDR_W=4, read 0x40: HRESP=1 for 2 cycles, HREADYOUT 0 then 1. Without the macro, the same read returns mem[0].

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared AHB-Lite encodings and FSM states for the sprite pixel slave.
// SPRITE_SLV_ERR_EN adds the two-cycle ERROR response states.
package sprite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2
`ifdef SPRITE_SLV_ERR_EN
      ,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
`endif
   } state_e;

   // Misaligned half/word accesses are forced onto their aligned lanes.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lane;
         HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sprite_ram.sv
// Sprite pixel store: single-port 32-bit array, byte-enable write, asynchronous read.
module sprite_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sprite_ahb_slave.sv
// AHB-Lite slave serving sprite/tile pixel words to the Printer with WAIT_STATES wait states.
// Optional SPRITE_SLV_ERR_EN: out-of-range address or oversize HSIZE gets an ERROR response.
//
// state | meaning
// IDLE  | no transfer in progress, zero-wait OKAY
// WAIT  | counting down wait states, HREADYOUT low
// DATA  | data phase: read drives HRDATA, write commits at cycle end
// ERR1  | first ERROR cycle, HREADYOUT low  (SPRITE_SLV_ERR_EN only)
// ERR2  | second ERROR cycle, HREADYOUT high (SPRITE_SLV_ERR_EN only)
module sprite_ahb_slave
   import sprite_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP
);

   localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_e            state_q, state_d, start_st;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        lane_q, lane_d;
   logic [2:0]        size_q, size_d;
   logic              write_q, write_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              accept;
   logic              ram_we;
   logic [31:0]       ram_rdata;
   logic              unused_ok;

   // HREADYOUT gate keeps the address latches stable if HREADY is ever misdriven during a stall.
   assign accept = HSEL & HTRANS[1] & HREADY & HREADYOUT;

`ifdef SPRITE_SLV_ERR_EN
   logic req_err;
   assign req_err   = (HADDR[31:ADDR_W+2] != '0) || (HSIZE > HSIZE_WORD);
   assign unused_ok = HTRANS[0];
`else
   assign unused_ok = ^{HADDR[31:ADDR_W+2], HTRANS[0]};
`endif

   always_comb begin
      start_st = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
`ifdef SPRITE_SLV_ERR_EN
      if (req_err) start_st = ST_ERR1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DATA: state_d = accept ? start_st : ST_IDLE;
         ST_WAIT:          if (cnt_q == 3'd0) state_d = ST_DATA;
`ifdef SPRITE_SLV_ERR_EN
         ST_ERR1:          state_d = ST_ERR2;
         ST_ERR2:          state_d = accept ? start_st : ST_IDLE;
`endif
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = rdata_q;
      ram_we    = 1'b0;
      case (state_q)
         ST_WAIT: HREADYOUT = 1'b0;
         ST_DATA: begin
            // A reset asserted in the data cycle abandons the write.
            if (write_q) ram_we = rst_n;
            else         HRDATA = ram_rdata;
         end
`ifdef SPRITE_SLV_ERR_EN
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
`endif
         default: ;
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      lane_d  = lane_q;
      size_d  = size_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = HADDR[ADDR_W+1:2];
         lane_d  = HADDR[1:0];
         size_d  = HSIZE;
         write_d = HWRITE;
         cnt_d   = WS_LOAD;
      end else if (state_q == ST_WAIT && cnt_q != 3'd0) begin
         cnt_d = cnt_q - 3'd1;
      end
      if (state_q == ST_DATA && !write_q) rdata_d = ram_rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         lane_q  <= 2'd0;
         size_q  <= 3'd0;
         write_q <= 1'b0;
         cnt_q   <= 3'd0;
         rdata_q <= 32'd0;
      end else begin
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   sprite_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .addr_i  (addr_q),
      .we_i    (ram_we),
      .be_i    (byte_lanes(size_q, lane_q)),
      .wdata_i (HWDATA),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_sprite_ahb_slave.sv
// Directed bench for sprite_ahb_slave: a 1-wait-state instance (ADDR_W=4) and a 0-wait-state instance.
module tb_sprite_ahb_slave;
   import sprite_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;

   logic        a_ro, a_rs, b_ro, b_rs;
   logic [31:0] a_rd, b_rd;
   logic        m_ro, m_rs;
   logic [31:0] m_rd;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int lows, resp_hi, t0;
   logic [31:0] got;
   logic        pend_w;
   logic [31:0] pend_wd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   sprite_ahb_slave #(.ADDR_W(4), .WAIT_STATES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .HSEL(HSEL & ~sel), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(a_ro),
      .HREADYOUT(a_ro), .HRDATA(a_rd), .HRESP(a_rs)
   );

   sprite_ahb_slave #(.ADDR_W(4), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .HSEL(HSEL & sel), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(b_ro),
      .HREADYOUT(b_ro), .HRDATA(b_rd), .HRESP(b_rs)
   );

   assign m_ro = sel ? b_ro : a_ro;
   assign m_rs = sel ? b_rs : a_rs;
   assign m_rd = sel ? b_rd : a_rd;

   function automatic logic [31:0] pat(input int i);
      logic [3:0] n;
      n = 4'(i);
      return {n, 4'h6, n, 4'h1, n, 4'h6, n, 4'h1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one address phase (or IDLE) plus write data for the pending data phase,
   // then run until the pending phase completes; results land in got/lows/resp_hi.
   task automatic step(input logic v, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] wd, input logic sq);
      int   n;
      logic rdy;
      logic done;
      HSEL   = 1'b1;
      HTRANS = v ? (sq ? HTRANS_SEQ : HTRANS_NONSEQ) : HTRANS_IDLE;
      HADDR  = a;
      HWRITE = w;
      HSIZE  = sz;
      HWDATA = pend_w ? pend_wd : 32'h0;
      lows = 0; resp_hi = 0; n = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         rdy = m_ro;
         if (m_ro === 1'b0) lows++;
         if (m_rs === 1'b1) resp_hi++;
         got = m_rd;
         @(posedge clk);
         n++;
         if (rdy === 1'b1) done = 1'b1;
         else if (n > 20) begin
            n_checks++;
            n_err++;
            $error("FAIL step_timeout: observed=no_ready expected=ready_within_20");
            done = 1'b1;
         end
      end
      #1;
      pend_w  = v & w;
      pend_wd = wd;
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0; HSIZE = HSIZE_WORD; HWDATA = '0; pend_w = 1'b0; pend_wd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hreadyout", {31'd0, a_ro}, 32'd1);
      check("rst_hresp",     {31'd0, a_rs}, 32'd0);
      check("rst_hrdata",    a_rd, 32'd0);
      rst_n = 1'b1;

      // preload words 0x00..0x1C on the 1-wait instance
      for (int i = 0; i < 8; i++) step(1'b1, 32'(i*4), 1'b1, HSIZE_WORD, pat(i), i != 0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'(i*4), 1'b0, HSIZE_WORD, 32'h0, i != 0);
         if (i > 0) begin
            check($sformatf("ws1_rd%0d", i-1),   got, pat(i-1));
            check($sformatf("ws1_low%0d", i-1),  32'(lows), 32'd1);
         end
      end
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("ws1_rd7",   got, pat(7));
      check("ws1_low7",  32'(lows), 32'd1);
      check("ws1_resp7", 32'(resp_hi), 32'd0);
      @(negedge clk);
      check("hrdata_hold", m_rd, pat(7));

      // BUSY must not be accepted: HREADYOUT stays high on the next cycle
      HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = 32'h0;
      @(posedge clk); #1;
      HTRANS = HTRANS_IDLE;
      @(negedge clk);
      check("busy_ignored", {31'd0, m_ro}, 32'd1);
      @(posedge clk); #1;

      // zero-wait instance: preload, then a 4-word stream
      sel = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i*4), 1'b1, HSIZE_WORD, pat(i), i != 0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'(i*4), 1'b0, HSIZE_WORD, 32'h0, i != 0);
         if (i > 0) begin
            check($sformatf("ws0_rd%0d", i-1),  got, pat(i-1));
            check($sformatf("ws0_low%0d", i-1), 32'(lows), 32'd0);
         end
      end
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("ws0_rd3",     got, pat(3));
      check("ws0_low3",    32'(lows), 32'd0);
      check("ws0_cycles",  32'(cyc - t0), 32'd5);

      step(1'b1, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
      step(1'b1, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("ws0_raw", got, 32'hDEAD_BEEF);
      sel = 1'b0;
      @(posedge clk); #1;

      // byte write into lane 1 of word 0x04
      step(1'b1, 32'h05, 1'b1, HSIZE_BYTE, 32'h0000_AA00, 1'b0);
      step(1'b1, 32'h04, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("byte_wr", got, 32'h1611_AA11);

      step(1'b1, 32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
      step(1'b1, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("ws1_raw", got, 32'hDEAD_BEEF);

      // reset asserted during the WAIT cycle of a write to 0x08
      step(1'b1, 32'h08, 1'b1, HSIZE_WORD, 32'h1234_5678, 1'b0);
      HTRANS = HTRANS_IDLE;
      HWDATA = 32'h1234_5678;
      rst_n  = 1'b0;
      @(posedge clk); #1;
      check("rstw_hreadyout", {31'd0, a_ro}, 32'd1);
      check("rstw_hrdata",    a_rd, 32'd0);
      rst_n  = 1'b1;
      pend_w = 1'b0;
      step(1'b1, 32'h08, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      check("rstw_old", got, pat(2));

      // read beyond the 16-word array
      step(1'b1, 32'h40, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
`ifdef SPRITE_SLV_ERR_EN
      check("err_resp_cycles", 32'(resp_hi), 32'd2);
      check("err_low_cycles",  32'(lows), 32'd1);
`else
      check("wrap_rd",   got, pat(0));
      check("wrap_resp", 32'(resp_hi), 32'd0);
      check("wrap_low",  32'(lows), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
